// File: rtl/mcb_port_responder.sv
// Single MCB user-port responder: command queue, 64-deep write/read FIFOs and a BRAM word store.
// Optional `MCB_RESP_BACKPRESSURE_EN: read bursts stall on a full read FIFO instead of dropping words.
module mcb_port_responder #(
    parameter int ADDR_WIDTH   = 12,
    parameter int CMD_DEPTH    = 4,
    parameter int RD_LATENCY   = 8,
    parameter int CALIB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        SYS_RESETn,
    input  logic        cmd_en,
    input  logic [2:0]  cmd_instr,
    input  logic [5:0]  cmd_bl,
    input  logic [29:0] cmd_byte_addr,
    output logic        cmd_full,
    input  logic        wr_en,
    input  logic [3:0]  wr_mask,
    input  logic [31:0] wr_data,
    output logic        wr_full,
    output logic        wr_empty,
    output logic [6:0]  wr_count,
    output logic        wr_underrun,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_empty,
    output logic        rd_full,
    output logic [6:0]  rd_count,
    output logic        rd_overflow,
    output logic        calib_done,
    output logic        error
);
    localparam int CQ_AW  = $clog2(CMD_DEPTH);
    localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);
    localparam int WAIT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WR_BURST, S_RD_WAIT, S_RD_BURST} state_t;
    typedef struct packed {
        logic                  rd;
        logic [5:0]            bl;
        logic [ADDR_WIDTH-1:0] addr;
    } cmd_t;

    cmd_t        cq_mem [CMD_DEPTH];
    logic [35:0] wf_mem [64];
    logic [31:0] rf_mem [64];
    logic [31:0] mem    [2**ADDR_WIDTH];
    logic [31:0] bram_rdata_q;

    state_t                state_q, state_d;
    logic [CAL_W-1:0]      cal_cnt_q, cal_cnt_d;
    logic                  calib_q, calib_d;
    logic [CQ_AW-1:0]      cq_wptr_q, cq_wptr_d, cq_rptr_q, cq_rptr_d;
    logic [CQ_AW:0]        cq_cnt_q, cq_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [5:0]            beat_q, beat_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [5:0]            wf_wptr_q, wf_wptr_d, wf_rptr_q, wf_rptr_d;
    logic [6:0]            wf_cnt_q, wf_cnt_d;
    logic [5:0]            rf_wptr_q, rf_wptr_d, rf_rptr_q, rf_rptr_d;
    logic [6:0]            rf_cnt_q, rf_cnt_d;
    logic [31:0]           rd_hold_q, rd_hold_d;
    logic                  underrun_q, underrun_d, overflow_q, overflow_d, error_q, error_d;

    logic        cmd_full_w, wr_full_w, rd_full_w, cmd_legal, cq_push, wf_push, rf_pop;
    logic        cq_pop, wf_pop, rf_push, mem_we, advance, underrun_set, overflow_set;
    cmd_t        cq_head;
    logic [35:0] wf_head;
    logic        unused_bits;

    // AP flag and address bits above the store are accepted but have no effect here
    assign unused_bits = ^{cmd_instr[1], cmd_byte_addr[29:ADDR_WIDTH+2]};

    assign cmd_full_w = (cq_cnt_q == (CQ_AW+1)'(CMD_DEPTH));
    assign wr_full_w  = (wf_cnt_q == 7'd64);
    assign rd_full_w  = (rf_cnt_q == 7'd64);
    assign cmd_legal  = !cmd_instr[2] && (cmd_byte_addr[1:0] == 2'b00);
    assign cq_push    = cmd_en && calib_q && !cmd_full_w && cmd_legal;
    assign wf_push    = wr_en && !wr_full_w;
    assign rf_pop     = rd_en && (rf_cnt_q != '0);
    assign cq_head    = cq_mem[cq_rptr_q];
    assign wf_head    = wf_mem[wf_rptr_q];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        wait_d       = wait_q;
        cq_pop       = 1'b0;
        wf_pop       = 1'b0;
        mem_we       = 1'b0;
        rf_push      = 1'b0;
        advance      = 1'b0;
        underrun_set = 1'b0;
        overflow_set = 1'b0;
        case (state_q)
            S_IDLE: if (cq_cnt_q != '0) state_d = S_DECODE;
            S_DECODE: begin
                cq_pop = 1'b1;
                addr_d = cq_head.addr;
                beat_d = cq_head.bl;
                if (!cq_head.rd) begin
                    state_d = S_WR_BURST;
                end else if (RD_LATENCY <= 1) begin
                    state_d = S_RD_BURST;
                end else begin
                    state_d = S_RD_WAIT;
                    wait_d  = WAIT_W'(RD_LATENCY - 2);
                end
            end
            S_WR_BURST: begin
                advance = 1'b1;
                if (wf_cnt_q != '0) begin
                    wf_pop = 1'b1;
                    mem_we = 1'b1;
                end else begin
                    underrun_set = 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (wait_q == '0) state_d = S_RD_BURST;
                else wait_d = wait_q - WAIT_W'(1);
            end
            S_RD_BURST: begin
`ifdef MCB_RESP_BACKPRESSURE_EN
                if (!rd_full_w) begin
                    rf_push = 1'b1;
                    advance = 1'b1;
                end
`else
                advance = 1'b1;
                if (rd_full_w) overflow_set = 1'b1;
                else rf_push = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (beat_q == '0) state_d = S_IDLE;
            else beat_d = beat_q - 6'd1;
        end
    end

    always_comb begin
        cal_cnt_d  = calib_q ? cal_cnt_q : cal_cnt_q + CAL_W'(1);
        calib_d    = calib_q || (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1));
        cq_wptr_d  = cq_push ? cq_wptr_q + CQ_AW'(1) : cq_wptr_q;
        cq_rptr_d  = cq_pop ? cq_rptr_q + CQ_AW'(1) : cq_rptr_q;
        cq_cnt_d   = cq_cnt_q + (CQ_AW+1)'(cq_push) - (CQ_AW+1)'(cq_pop);
        wf_wptr_d  = wf_push ? wf_wptr_q + 6'd1 : wf_wptr_q;
        wf_rptr_d  = wf_pop ? wf_rptr_q + 6'd1 : wf_rptr_q;
        wf_cnt_d   = wf_cnt_q + 7'(wf_push) - 7'(wf_pop);
        rf_wptr_d  = rf_push ? rf_wptr_q + 6'd1 : rf_wptr_q;
        rf_rptr_d  = rf_pop ? rf_rptr_q + 6'd1 : rf_rptr_q;
        rf_cnt_d   = rf_cnt_q + 7'(rf_push) - 7'(rf_pop);
        // last popped word keeps rd_data stable while the FIFO is empty
        rd_hold_d  = rf_pop ? rf_mem[rf_rptr_q] : rd_hold_q;
        underrun_d = underrun_q || underrun_set;
        overflow_d = overflow_q || overflow_set;
        error_d    = error_q || (cmd_en && (!calib_q || cmd_full_w || !cmd_legal))
                             || (wr_en && wr_full_w);
        rd_data    = (rf_cnt_q != '0) ? rf_mem[rf_rptr_q] : rd_hold_q;
    end

    always_ff @(posedge clk or negedge SYS_RESETn) begin
        if (!SYS_RESETn) begin
            state_q    <= S_IDLE;
            cal_cnt_q  <= '0;
            calib_q    <= 1'b0;
            cq_wptr_q  <= '0;
            cq_rptr_q  <= '0;
            cq_cnt_q   <= '0;
            addr_q     <= '0;
            beat_q     <= '0;
            wait_q     <= '0;
            wf_wptr_q  <= '0;
            wf_rptr_q  <= '0;
            wf_cnt_q   <= '0;
            rf_wptr_q  <= '0;
            rf_rptr_q  <= '0;
            rf_cnt_q   <= '0;
            rd_hold_q  <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cal_cnt_q  <= cal_cnt_d;
            calib_q    <= calib_d;
            cq_wptr_q  <= cq_wptr_d;
            cq_rptr_q  <= cq_rptr_d;
            cq_cnt_q   <= cq_cnt_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            wait_q     <= wait_d;
            wf_wptr_q  <= wf_wptr_d;
            wf_rptr_q  <= wf_rptr_d;
            wf_cnt_q   <= wf_cnt_d;
            rf_wptr_q  <= rf_wptr_d;
            rf_rptr_q  <= rf_rptr_d;
            rf_cnt_q   <= rf_cnt_d;
            rd_hold_q  <= rd_hold_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
        end
    end

    // storage arrays carry no reset; the store reads addr_d so the word for addr_q is ready in RD_BURST
    always_ff @(posedge clk) begin
        if (cq_push) cq_mem[cq_wptr_q] <= '{rd: cmd_instr[0], bl: cmd_bl, addr: cmd_byte_addr[ADDR_WIDTH+1:2]};
        if (wf_push) wf_mem[wf_wptr_q] <= {wr_mask, wr_data};
        if (rf_push) rf_mem[rf_wptr_q] <= bram_rdata_q;
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (!wf_head[32+b]) mem[addr_q][8*b +: 8] <= wf_head[8*b +: 8];
            end
        end
        bram_rdata_q <= mem[addr_d];
    end

    assign cmd_full    = cmd_full_w;
    assign wr_full     = wr_full_w;
    assign wr_empty    = (wf_cnt_q == '0);
    assign wr_count    = wf_cnt_q;
    assign wr_underrun = underrun_q;
    assign rd_empty    = (rf_cnt_q == '0);
    assign rd_full     = rd_full_w;
    assign rd_count    = rf_cnt_q;
    assign rd_overflow = overflow_q;
    assign calib_done  = calib_q;
    assign error       = error_q;
endmodule

// File: tb/tb_mcb_port_responder.sv
// Randomized bench for mcb_port_responder against a word-level memory/FIFO reference model.
module tb_mcb_port_responder;
    localparam int AW  = 12;
    localparam int RDL = 8;
    localparam int CAL = 16;
`ifdef MCB_RESP_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        SYS_RESETn, cmd_en, wr_en, rd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data, rd_data;
    logic        cmd_full, wr_full, wr_empty, wr_underrun, rd_empty, rd_full, rd_overflow, calib_done, error;
    logic [6:0]  wr_count, rd_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mmem [2**AW];
    logic [35:0] wq[$];
    logic [31:0] expq[$];

    always #5 clk = ~clk;

    mcb_port_responder #(.ADDR_WIDTH(AW), .CMD_DEPTH(4), .RD_LATENCY(RDL), .CALIB_CYCLES(CAL)) dut (
        .clk(clk), .SYS_RESETn(SYS_RESETn),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full), .wr_empty(wr_empty),
        .wr_count(wr_count), .wr_underrun(wr_underrun),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_full(rd_full), .rd_count(rd_count),
        .rd_overflow(rd_overflow), .calib_done(calib_done), .error(error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
        wr_data = d;
        wr_mask = m;
        wr_en   = 1'b1;
        tick(1);
        wr_en   = 1'b0;
        if (wq.size() < 64) wq.push_back({m, d});
    endtask

    // Model executes each legal command immediately; bench never drains while a read is pending.
    task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
        logic [AW-1:0] idx;
        logic [35:0]   w;
        cmd_instr     = instr;
        cmd_bl        = bl;
        cmd_byte_addr = addr;
        cmd_en        = 1'b1;
        tick(1);
        cmd_en        = 1'b0;
        if (instr[2] || addr[1:0] != 2'b00) return;
        idx = addr[AW+1:2];
        for (int unsigned i = 0; i <= bl; i++) begin
            if (!instr[0]) begin
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    for (int unsigned b = 0; b < 4; b++)
                        if (!w[32+b]) mmem[idx][8*b +: 8] = w[8*b +: 8];
                end
            end else if (BP || expq.size() < 64) begin
                expq.push_back(mmem[idx]);
            end
            idx = idx + 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (expq.size() != 0) begin
            int w = 0;
            while (rd_empty && w < 300) begin
                tick(1);
                w++;
            end
            if (rd_empty) begin
                check_eq($sformatf("%s_timeout_word%0d", tag, n), {31'b0, rd_empty}, 32'd0);
                expq.delete();
            end else begin
                check_eq($sformatf("%s_word%0d", tag, n), rd_data, expq.pop_front());
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
                n++;
            end
        end
        check_eq({tag, "_empty_after"}, {31'b0, rd_empty}, 32'd1);
    endtask

    task automatic calib_check(input string tag);
        for (int i = 1; i <= CAL + 2; i++) begin
            tick(1);
            if (i == CAL - 1) check_eq({tag, "_calib_early"}, {31'b0, calib_done}, 32'd0);
            if (i == CAL)     check_eq({tag, "_calib_rise"}, {31'b0, calib_done}, 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0]  bl;
        logic [29:0] addr;
        SYS_RESETn = 1'b0; cmd_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        cmd_instr = '0; cmd_bl = '0; cmd_byte_addr = '0; wr_mask = '0; wr_data = '0;

        // 1: reset state and calibration timing
        tick(3);
        check_eq("rst_wr_empty", {31'b0, wr_empty}, 32'd1);
        check_eq("rst_rd_empty", {31'b0, rd_empty}, 32'd1);
        check_eq("rst_flags", {25'b0, cmd_full, wr_full, rd_full, wr_underrun, rd_overflow, calib_done, error}, 32'd0);
        check_eq("rst_counts", {18'b0, wr_count, rd_count}, 32'd0);
        check_eq("rst_rd_data", rd_data, 32'd0);
        SYS_RESETn = 1'b1;
        calib_check("t1");
        check_eq("t1_error", {31'b0, error}, 32'd0);

        // 2: simple write then read back
        push_wr(32'h11111111, 4'h0); push_wr(32'h22222222, 4'h0);
        push_wr(32'h33333333, 4'h0); push_wr(32'h44444444, 4'h0);
        check_eq("t2_wr_count", {25'b0, wr_count}, 32'd4);
        send_cmd(3'b000, 6'd3, 30'h100);
        send_cmd(3'b001, 6'd3, 30'h100);
        tick(30);
        check_eq("t2_rd_count", {25'b0, rd_count}, 32'd4);
        check_eq("t2_wr_empty", {31'b0, wr_empty}, 32'd1);
        check_eq("t2_head", rd_data, 32'h11111111);
        drain("t2");
        check_eq("t2_error", {31'b0, error}, 32'd0);

        // 3: byte mask
        push_wr(32'h12345678, 4'h0);
        send_cmd(3'b000, 6'd0, 30'h200);
        push_wr(32'hAABBCCDD, 4'b0011);
        send_cmd(3'b010, 6'd0, 30'h200);
        send_cmd(3'b011, 6'd0, 30'h200);
        tick(30);
        check_eq("t3_masked", rd_data, 32'hAABB5678);
        drain("t3");

        // random write/masked-write/read sequences at arbitrary (upper-bit-laden) addresses
        for (int it = 0; it < 12; it++) begin
            bl   = 6'($urandom_range(0, 31));
            addr = {$urandom(), 2'b00};
            for (int unsigned i = 0; i <= bl; i++) push_wr($urandom(), 4'h0);
            send_cmd(3'b000, bl, addr);
            for (int unsigned i = 0; i <= bl; i++) push_wr($urandom(), 4'($urandom()));
            send_cmd(3'b000, bl, addr);
            send_cmd(3'b001, bl, addr);
            tick(3 * int'(bl) + 40);
            drain($sformatf("rnd%0d", it));
        end
        check_eq("rnd_error", {31'b0, error}, 32'd0);

        // 4: fill 128 words, then two full-length reads with the read FIFO never drained
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 64; i++) push_wr($urandom(), 4'h0);
            if (r == 0) begin
                check_eq("t4_wr_full", {31'b0, wr_full}, 32'd1);
                check_eq("t4_wr_count", {25'b0, wr_count}, 32'd64);
            end
            send_cmd(3'b000, 6'd63, 30'h1000 + 30'(r * 256));
            tick(80);
        end
        send_cmd(3'b001, 6'd63, 30'h1000);
        send_cmd(3'b001, 6'd63, 30'h1100);
        tick(200);
        check_eq("t4_rd_count", {25'b0, rd_count}, 32'd64);
        check_eq("t4_rd_full", {31'b0, rd_full}, 32'd1);
        check_eq("t4_rd_overflow", {31'b0, rd_overflow}, BP ? 32'd0 : 32'd1);
        drain("t4");

        // 5: underrun, illegal instruction, write-FIFO overfill, address wrap
        push_wr(32'hCAFEF00D, 4'h0);
        send_cmd(3'b000, 6'd0, 30'h0);
        tick(20);
        check_eq("t5_underrun_pre", {31'b0, wr_underrun}, 32'd0);
        send_cmd(3'b000, 6'd1, 30'h0);
        tick(20);
        check_eq("t5_underrun", {31'b0, wr_underrun}, 32'd1);
        check_eq("t5_error_pre", {31'b0, error}, 32'd0);
        send_cmd(3'b001, 6'd0, 30'h0);
        tick(30);
        check_eq("t5_word0", rd_data, 32'hCAFEF00D);
        drain("t5a");
        send_cmd(3'b100, 6'd0, 30'h0);
        tick(2);
        check_eq("t5_illegal_error", {31'b0, error}, 32'd1);
        for (int i = 0; i < 65; i++) push_wr($urandom(), 4'($urandom()));
        check_eq("t5_wr_count_cap", {25'b0, wr_count}, 32'd64);
        for (int i = 0; i < 64; i++) wq[i][35:32] = wq[i][35:32];
        push_wr(32'hDEADBEEF, 4'h0);
        send_cmd(3'b000, 6'd63, 30'h3000);
        tick(80);
        check_eq("t5_wr_empty", {31'b0, wr_empty}, 32'd1);
        send_cmd(3'b001, 6'd63, 30'h3000);
        tick(100);
        drain("t5b");
        push_wr(32'h0BADCAFE, 4'h0); push_wr(32'h600DF00D, 4'h0);
        send_cmd(3'b000, 6'd1, 30'h0010_3FFC);
        send_cmd(3'b001, 6'd1, 30'h3FFC);
        tick(30);
        check_eq("t5_wrap_first", rd_data, 32'h0BADCAFE);
        drain("t5c");

        // 6: reset in the middle of a read burst; store contents survive
        send_cmd(3'b001, 6'd63, 30'h1000);
        tick(RDL + 10);
        check_eq("t6_midburst", {31'b0, rd_count != 7'd0}, 32'd1);
        SYS_RESETn = 1'b0;
        #1;
        expq.delete();
        wq.delete();
        check_eq("t6_rd_count", {25'b0, rd_count}, 32'd0);
        check_eq("t6_calib_low", {31'b0, calib_done}, 32'd0);
        check_eq("t6_flags", {29'b0, error, rd_overflow, wr_underrun}, 32'd0);
        tick(2);
        SYS_RESETn = 1'b1;
        calib_check("t6");
        check_eq("t6_rd_data", rd_data, 32'd0);
        send_cmd(3'b001, 6'd15, 30'h1000);
        tick(40);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
